// File: rtl/gencolorclk_nco.sv
// Colour-carrier NCO: phase accumulator with a selectable increment table, a run-time
// override, and increment changes deferred to accumulator wrap so the carrier never glitches.
module gencolorclk_nco #(
   parameter int ACC_W     = 32,
   parameter int NUM_MODES = 4,
   parameter int MODE_W    = 2,
   parameter int PHASE_W   = 8,
   parameter logic [NUM_MODES*ACC_W-1:0] INC_TABLE =
      {32'd393575136, 32'd487481536, 32'd439257960, 32'd544064216}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [MODE_W-1:0]  mode,
   input  logic               inc_load,
   input  logic [ACC_W-1:0]   inc_value,
   input  logic               phase_clr,
   output logic               clk_i,
   output logic               clk_q,
   output logic [PHASE_W-1:0] phase,
   output logic               tick,
   output logic               pending,
   output logic [ACC_W-1:0]   inc_cur
);

   // Table lookup; selections beyond the populated entries fall back to entry 0.
   function automatic logic [ACC_W-1:0] table_inc(input logic [MODE_W-1:0] m);
      logic [ACC_W-1:0] r;
      r = INC_TABLE[ACC_W-1:0];
      for (int k = 0; k < NUM_MODES; k++) begin
         if (m == MODE_W'(k)) begin
            r = INC_TABLE[k*ACC_W +: ACC_W];
         end
      end
      return r;
   endfunction

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              clk_q_q, clk_q_d;
   logic              tick_q, tick_d;
   logic              pending_q, pending_d;
   logic [ACC_W-1:0]  inc_cur_q, inc_cur_d;
   logic [ACC_W-1:0]  inc_pend_q, inc_pend_d;
   logic [MODE_W-1:0] mode_meta_q, mode_s_q;
   logic [MODE_W-1:0] mode_last_q, mode_last_d;

   logic [ACC_W:0]    sum_s;
   logic              carry_s;
   logic              mode_chg_s;
   logic              req_s;
   logic [ACC_W-1:0]  req_val_s;

   // Adder with carry-out and request arbitration (override beats table selection).
   always_comb begin
      sum_s      = {1'b0, acc_q} + {1'b0, inc_cur_q};
      carry_s    = sum_s[ACC_W];
      mode_chg_s = (mode_s_q != mode_last_q);
      req_s      = inc_load | mode_chg_s;
      req_val_s  = inc_load ? inc_value : table_inc(mode_s_q);
   end

   // Next-state logic: phase_clr over advance; increment swaps only at wrap or restart.
   always_comb begin
      acc_d       = acc_q;
      clk_q_d     = clk_q_q;
      tick_d      = 1'b0;
      pending_d   = pending_q;
      inc_cur_d   = inc_cur_q;
      inc_pend_d  = inc_pend_q;
      mode_last_d = mode_chg_s ? mode_s_q : mode_last_q;
      if (phase_clr) begin
         acc_d   = {ACC_W{1'b0}};
         clk_q_d = 1'b0;
         tick_d  = 1'b0;
         if (req_s) begin
            inc_cur_d  = req_val_s;
            inc_pend_d = req_val_s;
            pending_d  = 1'b0;
         end else if (pending_q) begin
            inc_cur_d = inc_pend_q;
            pending_d = 1'b0;
         end else begin
            inc_cur_d = inc_cur_q;
         end
      end else begin
         if (en) begin
            acc_d   = sum_s[ACC_W-1:0];
            tick_d  = carry_s;
            clk_q_d = sum_s[ACC_W-1] ^ sum_s[ACC_W-2];
            if (carry_s && pending_q) begin
               inc_cur_d = inc_pend_q;
               pending_d = 1'b0;
            end else begin
               inc_cur_d = inc_cur_q;
            end
         end else begin
            tick_d = 1'b0;
         end
         // A request landing on the carry cycle stays pending for the next wrap.
         if (req_s) begin
            inc_pend_d = req_val_s;
            pending_d  = 1'b1;
         end else begin
            inc_pend_d = inc_pend_q;
         end
      end
   end

   // State registers, including the two-stage mode synchroniser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= {ACC_W{1'b0}};
         clk_q_q     <= 1'b0;
         tick_q      <= 1'b0;
         pending_q   <= 1'b0;
         inc_cur_q   <= INC_TABLE[ACC_W-1:0];
         inc_pend_q  <= INC_TABLE[ACC_W-1:0];
         mode_meta_q <= {MODE_W{1'b0}};
         mode_s_q    <= {MODE_W{1'b0}};
         mode_last_q <= {MODE_W{1'b0}};
      end else begin
         acc_q       <= acc_d;
         clk_q_q     <= clk_q_d;
         tick_q      <= tick_d;
         pending_q   <= pending_d;
         inc_cur_q   <= inc_cur_d;
         inc_pend_q  <= inc_pend_d;
         mode_meta_q <= mode;
         mode_s_q    <= mode_meta_q;
         mode_last_q <= mode_last_d;
      end
   end

   assign clk_i   = acc_q[ACC_W-1];
   assign clk_q   = clk_q_q;
   assign phase   = acc_q[ACC_W-1 -: PHASE_W];
   assign tick    = tick_q;
   assign pending = pending_q;
   assign inc_cur = inc_cur_q;

endmodule

// File: tb/tb_gencolorclk_nco.sv
// Bench for gencolorclk_nco: a default 32-bit instance plus two 8-bit instances
// (four-entry table, and a three-entry table for out-of-range selection).
module tb_gencolorclk_nco;

   logic        clk, rst_n, en, inc_load, phase_clr;
   logic [1:0]  mode, mode_x;
   logic [7:0]  inc_value;
   logic [31:0] inc_value32;

   logic        w_clk_i, w_clk_q, w_tick, w_pending;
   logic [7:0]  w_phase;
   logic [31:0] w_inc_cur;
   logic        clk_i8, clk_q8, tick8, pending8;
   logic [7:0]  phase8, inc_cur8;
   logic        x_clk_i, x_clk_q, x_tick, x_pending;
   logic [7:0]  x_phase, x_inc_cur;

   int n_cmp = 0;
   int n_err = 0;
   int exp_q[$];

   gencolorclk_nco dut32 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inc_load(inc_load),
      .inc_value(inc_value32), .phase_clr(phase_clr), .clk_i(w_clk_i), .clk_q(w_clk_q),
      .phase(w_phase), .tick(w_tick), .pending(w_pending), .inc_cur(w_inc_cur));

   gencolorclk_nco #(.ACC_W(8), .NUM_MODES(4), .MODE_W(2), .PHASE_W(8),
      .INC_TABLE({8'd128, 8'd16, 8'd64, 8'd32})) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inc_load(inc_load),
      .inc_value(inc_value), .phase_clr(phase_clr), .clk_i(clk_i8), .clk_q(clk_q8),
      .phase(phase8), .tick(tick8), .pending(pending8), .inc_cur(inc_cur8));

   gencolorclk_nco #(.ACC_W(8), .NUM_MODES(3), .MODE_W(2), .PHASE_W(8),
      .INC_TABLE({8'd16, 8'd64, 8'd32})) dut8x (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_x), .inc_load(inc_load),
      .inc_value(inc_value), .phase_clr(phase_clr), .clk_i(x_clk_i), .clk_q(x_clk_q),
      .phase(x_phase), .tick(x_tick), .pending(x_pending), .inc_cur(x_inc_cur));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en = 1'b0; inc_load = 1'b0; phase_clr = 1'b0; mode = 2'd0; mode_x = 2'd0;
      inc_value = 8'd0; inc_value32 = 32'd0; rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      en = 1'b1; inc_load = 1'b0; phase_clr = 1'b0; mode = 2'd0; mode_x = 2'd0;
      inc_value = 8'd0; inc_value32 = 32'd0; rst_n = 1'b0;
      step(); step();
      n_cmp++; if (w_inc_cur !== 32'd544064216) begin n_err++; $display("FAIL rst_inc_cur: got %0d want 544064216", w_inc_cur); end
      n_cmp++; if ({w_clk_i, w_clk_q, w_tick, w_pending} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {w_clk_i, w_clk_q, w_tick, w_pending}); end
      n_cmp++; if (w_phase !== 8'd0) begin n_err++; $display("FAIL rst_phase: got %0d want 0", w_phase); end
      n_cmp++; if (inc_cur8 !== 8'd32) begin n_err++; $display("FAIL rst_inc_cur8: got %0d want 32", inc_cur8); end
      rst_n = 1'b1;
      step();
      n_cmp++; if (w_phase !== 8'd32) begin n_err++; $display("FAIL first_phase: got %0d want 32", w_phase); end
      n_cmp++; if ({w_clk_i, w_clk_q, w_tick, w_pending} !== 4'b0000) begin n_err++; $display("FAIL first_flags: got %b want 0000", {w_clk_i, w_clk_q, w_tick, w_pending}); end
      n_cmp++; if (phase8 !== 8'd32) begin n_err++; $display("FAIL first_phase8: got %0d want 32", phase8); end
   endtask

   task automatic test_tick_period();
      int e, j;
      logic [7:0] ep;
      do_reset();
      en = 1'b1;
      for (int i = 1; i <= 8; i++) exp_q.push_back(8 * i);
      for (int k = 1; k <= 64; k++) begin
         step();
         if (tick8) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL period_tick: unexpected tick at cycle %0d", k); end
            else begin e = exp_q.pop_front(); if (k != e) begin n_err++; $display("FAIL period_tick: tick at cycle %0d want %0d", k, e); end end
         end
         j  = k % 8;
         ep = 8'(32 * k);
         n_cmp++; if (phase8 !== ep) begin n_err++; $display("FAIL period_phase: cycle %0d got %0d want %0d", k, phase8, ep); end
         n_cmp++; if (clk_i8 !== (j >= 4)) begin n_err++; $display("FAIL period_clk_i: cycle %0d got %b want %b", k, clk_i8, (j >= 4)); end
         n_cmp++; if (clk_q8 !== (j >= 2 && j <= 5)) begin n_err++; $display("FAIL period_clk_q: cycle %0d got %b want %b", k, clk_q8, (j >= 2 && j <= 5)); end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL period_missing: %0d ticks not seen, want 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_switch();
      int e;
      do_reset();
      en = 1'b1;
      exp_q.push_back(8); exp_q.push_back(12); exp_q.push_back(16); exp_q.push_back(20);
      for (int k = 1; k <= 20; k++) begin
         step();
         if (tick8) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL switch_tick: unexpected tick at cycle %0d", k); end
            else begin e = exp_q.pop_front(); if (k != e) begin n_err++; $display("FAIL switch_tick: tick at cycle %0d want %0d", k, e); end end
         end
         if (k == 3) mode = 2'd1;
         if (k == 5) begin n_cmp++; if (pending8 !== 1'b0) begin n_err++; $display("FAIL switch_pend_early: got %b want 0", pending8); end end
         if (k == 6) begin n_cmp++; if (pending8 !== 1'b1) begin n_err++; $display("FAIL switch_pend_set: got %b want 1", pending8); end end
         if (k == 7) begin n_cmp++; if (inc_cur8 !== 8'd32) begin n_err++; $display("FAIL switch_inc_hold: got %0d want 32", inc_cur8); end end
         if (k == 8) begin
            n_cmp++; if (inc_cur8 !== 8'd64) begin n_err++; $display("FAIL switch_inc_new: got %0d want 64", inc_cur8); end
            n_cmp++; if (pending8 !== 1'b0) begin n_err++; $display("FAIL switch_pend_clr: got %b want 0", pending8); end
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL switch_missing: %0d ticks not seen, want 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_override();
      int e;
      do_reset();
      mode = 2'd3;
      exp_q.push_back(20); exp_q.push_back(52); exp_q.push_back(56); exp_q.push_back(60);
      for (int k = 1; k <= 60; k++) begin
         step();
         if (tick8) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL ovr_tick: unexpected tick at cycle %0d", k); end
            else begin e = exp_q.pop_front(); if (k != e) begin n_err++; $display("FAIL ovr_tick: tick at cycle %0d want %0d", k, e); end end
         end
         inc_load = 1'b0;
         if (k == 2) begin inc_load = 1'b1; inc_value = 8'd16; end
         if (k == 3) begin
            n_cmp++; if (pending8 !== 1'b1) begin n_err++; $display("FAIL ovr_pend: got %b want 1", pending8); end
            n_cmp++; if (inc_cur8 !== 8'd32) begin n_err++; $display("FAIL ovr_inc_hold: got %0d want 32", inc_cur8); end
            phase_clr = 1'b1;
         end
         if (k == 4) begin
            n_cmp++; if (inc_cur8 !== 8'd16) begin n_err++; $display("FAIL clr_inc: got %0d want 16", inc_cur8); end
            n_cmp++; if ({pending8, tick8} !== 2'b00) begin n_err++; $display("FAIL clr_flags: got %b want 00", {pending8, tick8}); end
            n_cmp++; if (phase8 !== 8'd0) begin n_err++; $display("FAIL clr_phase: got %0d want 0", phase8); end
            phase_clr = 1'b0; en = 1'b1;
         end
         if (k == 6) begin n_cmp++; if (pending8 !== 1'b0) begin n_err++; $display("FAIL ovr_mode_last: got %b want 0", pending8); end end
         if (k == 9)  begin inc_load = 1'b1; inc_value = 8'd40; end
         if (k == 11) begin inc_load = 1'b1; inc_value = 8'd8; end
         if (k == 12) begin
            n_cmp++; if ({pending8, inc_cur8} !== {1'b1, 8'd16}) begin n_err++; $display("FAIL ovr_wait: got %b/%0d want 1/16", pending8, inc_cur8); end
         end
         if (k == 19) begin inc_load = 1'b1; inc_value = 8'd64; end
         if (k == 20) begin
            n_cmp++; if (inc_cur8 !== 8'd8) begin n_err++; $display("FAIL carry_req_inc: got %0d want 8", inc_cur8); end
            n_cmp++; if (pending8 !== 1'b1) begin n_err++; $display("FAIL carry_req_pend: got %b want 1", pending8); end
         end
         if (k == 52) begin
            n_cmp++; if ({pending8, inc_cur8} !== {1'b0, 8'd64}) begin n_err++; $display("FAIL carry_req_apply: got %b/%0d want 0/64", pending8, inc_cur8); end
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ovr_missing: %0d ticks not seen, want 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_out_of_range();
      do_reset();
      mode_x = 2'd1;
      step(); step(); step();
      n_cmp++; if ({x_pending, x_inc_cur} !== {1'b1, 8'd32}) begin n_err++; $display("FAIL oor_pend1: got %b/%0d want 1/32", x_pending, x_inc_cur); end
      phase_clr = 1'b1; step(); phase_clr = 1'b0;
      n_cmp++; if ({x_pending, x_inc_cur} !== {1'b0, 8'd64}) begin n_err++; $display("FAIL oor_mode1: got %b/%0d want 0/64", x_pending, x_inc_cur); end
      mode_x = 2'd3;
      step(); step(); step();
      n_cmp++; if (x_pending !== 1'b1) begin n_err++; $display("FAIL oor_pend3: got %b want 1", x_pending); end
      phase_clr = 1'b1; step(); phase_clr = 1'b0;
      n_cmp++; if ({x_pending, x_inc_cur} !== {1'b0, 8'd32}) begin n_err++; $display("FAIL oor_fallback: got %b/%0d want 0/32", x_pending, x_inc_cur); end
      n_cmp++; if ({x_clk_i, x_clk_q, x_tick, x_phase} !== 11'd0) begin n_err++; $display("FAIL oor_outputs: got %b want 0", {x_clk_i, x_clk_q, x_tick, x_phase}); end
   endtask

   task automatic test_en_hold();
      int e;
      do_reset();
      en = 1'b1;
      step(); step(); step();
      n_cmp++; if (phase8 !== 8'd96) begin n_err++; $display("FAIL hold_start: got %0d want 96", phase8); end
      en = 1'b0; mode = 2'd1;
      for (int k = 1; k <= 10; k++) begin
         step();
         n_cmp++; if ({phase8, tick8, inc_cur8} !== {8'd96, 1'b0, 8'd32}) begin n_err++; $display("FAIL hold_state: cycle %0d got %0d/%b/%0d want 96/0/32", k, phase8, tick8, inc_cur8); end
      end
      n_cmp++; if (pending8 !== 1'b1) begin n_err++; $display("FAIL hold_pend: got %b want 1", pending8); end
      en = 1'b1;
      exp_q.push_back(5); exp_q.push_back(9);
      for (int k = 1; k <= 9; k++) begin
         step();
         if (tick8) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL resume_tick: unexpected tick at cycle %0d", k); end
            else begin e = exp_q.pop_front(); if (k != e) begin n_err++; $display("FAIL resume_tick: tick at cycle %0d want %0d", k, e); end end
         end
         if (k == 4) begin n_cmp++; if (inc_cur8 !== 8'd32) begin n_err++; $display("FAIL resume_inc_old: got %0d want 32", inc_cur8); end end
         if (k == 5) begin n_cmp++; if ({pending8, inc_cur8} !== {1'b0, 8'd64}) begin n_err++; $display("FAIL resume_switch: got %b/%0d want 0/64", pending8, inc_cur8); end end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL resume_missing: %0d ticks not seen, want 0", exp_q.size()); exp_q.delete(); end
      mode = 2'd2;
      step(); step(); step();
      n_cmp++; if (pending8 !== 1'b1) begin n_err++; $display("FAIL mid_pend: got %b want 1", pending8); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({pending8, inc_cur8, phase8} !== {1'b0, 8'd32, 8'd0}) begin n_err++; $display("FAIL mid_reset: got %b/%0d/%0d want 0/32/0", pending8, inc_cur8, phase8); end
      mode = 2'd0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_tick_period();
      test_switch();
      test_override();
      test_out_of_range();
      test_en_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
